mgmt_uart: RTL and testbench

MGMT_UART -- requirements
Module: mgmt_uart

---
 rtl/mgmt_uart_if.sv | 24 ++
 rtl/mgmt_uart.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mgmt_uart.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_uart_if.sv
// Host-side bus of the management UART: RX word strobes out, TX word pushes in.
// Latency: none, wires only.
// Backpressure: tx_ready gates tx_en; the RX strobes cannot be stalled.
interface mgmt_uart_if;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;

  // Host side drives pushes and consumes strobes
  modport master (
    output tx_en, tx_data,
    input  rx_en, rx_data, rx_frame_err, tx_ready, tx_busy
  );

  // UART side consumes pushes and drives strobes
  modport slave (
    input  tx_en, tx_data,
    output rx_en, rx_data, rx_frame_err, tx_ready, tx_busy
  );
endinterface

// File: rtl/mgmt_uart.sv
// 8N1 management UART: synchronized RX with glitch reject, FIFO-buffered TX, activity/error LEDs.
// Latency: rx strobe one cycle after the stop-bit sample; TX start bit 2 clocks after a push into an idle, empty path.
// Backpressure: tx_ready is registered FIFO-not-full; pushes while not ready are dropped and flagged on led[3].
module mgmt_uart #(
  parameter int CLK_DIV       = 217,
  parameter int DATA_BITS     = 8,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int LED_STRETCH   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       led_clr,
  output logic [3:0] led,
  mgmt_uart_if.slave bus
);
  localparam int PW   = $clog2(TX_FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int HALF = CLK_DIV / 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // ---------------- RX ----------------
  logic                 rxd_s1_q, rxd_s2_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_en_q, rx_en_d, rx_ferr_q, rx_ferr_d;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= uart_rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // RX next state: half-bit start check, then one sample per bit time
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_en_d    = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rxd_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == 16'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'(CLK_DIV - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = S_STOP;
          else                               rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'(CLK_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rxd_s2_q) begin
            rx_en_d   = 1'b1;
            rx_data_d = 8'(rx_sh_q);
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state register; reset drops any partial frame without a strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_en_q    <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_en_q    <= rx_en_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign bus.rx_en        = rx_en_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_frame_err = rx_ferr_q;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem_q [TX_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 push, pop, overflow;

  // tx_ready is registered, so a pop while full cannot admit a same-cycle push
  assign push     = bus.tx_en && tx_ready_q;
  assign overflow = bus.tx_en && !tx_ready_q;

  // FIFO pointer/occupancy next state; power-of-2 depth wraps naturally
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    tx_ready_d = (fifo_cnt_d != CW'(TX_FIFO_DEPTH));
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.tx_data[DATA_BITS-1:0];
  end

  // FIFO control registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // ---------------- TX ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 txd_q, txd_d;

  // TX next state; a pop always coincides with entering START, and the line level follows the next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    pop        = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (fifo_cnt_q != '0) begin
          pop        = 1'b1;
          tx_sh_d    = fifo_mem_q[rd_ptr_q];
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'(CLK_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'(CLK_DIV - 1)) begin
          tx_cnt_d = '0;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = S_STOP;
          else                               tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'(CLK_DIV - 1)) begin
          tx_cnt_d = '0;
          if (fifo_cnt_q != '0) begin
            pop        = 1'b1;
            tx_sh_d    = fifo_mem_q[rd_ptr_q];
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // TX state register; reset returns the line to idle immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd     = txd_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = (fifo_cnt_q != '0) || (tx_state_q != S_IDLE);

  // ---------------- LEDs ----------------
  logic [23:0] led0_cnt_q, led0_cnt_d, led1_cnt_q, led1_cnt_d;
  logic        led2_q, led2_d, led3_q, led3_d;

  // Stretch counters reload on activity; sticky bits give set priority over clear
  always_comb begin
    led0_cnt_d = rx_en_d ? 24'(LED_STRETCH) : (led0_cnt_q != '0 ? led0_cnt_q - 24'd1 : led0_cnt_q);
    led1_cnt_d = pop     ? 24'(LED_STRETCH) : (led1_cnt_q != '0 ? led1_cnt_q - 24'd1 : led1_cnt_q);
    led2_d     = rx_ferr_d | (led2_q & ~led_clr);
    led3_d     = overflow  | (led3_q & ~led_clr);
  end

  // LED state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led0_cnt_q <= '0;
      led1_cnt_q <= '0;
      led2_q     <= 1'b0;
      led3_q     <= 1'b0;
    end else begin
      led0_cnt_q <= led0_cnt_d;
      led1_cnt_q <= led1_cnt_d;
      led2_q     <= led2_d;
      led3_q     <= led3_d;
    end
  end

  assign led = {led3_q, led2_q, (led1_cnt_q != '0), (led0_cnt_q != '0)};
endmodule

// File: tb/tb_mgmt_uart.sv
// Directed bench for mgmt_uart: RX vector table, then TX timing, overflow and reset sequences.
// Latency: outputs sampled on the falling clock edge.
// Backpressure: exercises FIFO full / dropped push behaviour.
module tb_mgmt_uart;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 4;
  localparam int STRETCH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic       led_clr = 1'b0;
  logic [3:0] led;

  mgmt_uart_if bus ();

  mgmt_uart #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .TX_FIFO_DEPTH(DEPTH), .LED_STRETCH(STRETCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .led_clr(led_clr), .led(led), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Strobe / LED monitor, sampled on the falling edge
  int         rx_cnt = 0;
  int         fe_cnt = 0;
  int         led0_cyc = 0;
  always @(negedge clk) begin
    if (bus.rx_en === 1'b1) rx_cnt++;
    if (bus.rx_frame_err === 1'b1) fe_cnt++;
    if (led[0] === 1'b1) led0_cyc++;
  end

  // Line decoder for uart_txd: records start-bit cycle and {stop, data}
  int         tx_starts[$];
  logic [8:0] tx_words[$];
  logic [7:0] dec_v;
  initial begin
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        tx_starts.push_back(cyc);
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CLK_DIV) @(negedge clk);
          dec_v[b] = uart_txd;
        end
        repeat (CLK_DIV) @(negedge clk);
        tx_words.push_back({uart_txd, dec_v});
      end
    end
  end

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      uart_rxd = d[b];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         exp_en;
    int         exp_fe;
    logic [7:0] exp_dat;
    logic       exp_led2;
    int         exp_led0;
  } rx_vec_t;

  rx_vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc, n0, k, r0, f0, l0;
    logic [7:0] exp_w[5];

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 1'b0, STRETCH};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00, 1'b1, STRETCH};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 1'b1, STRETCH};
    vecs[4] = '{8'h81, 1'b0, 0, 1, 8'hFF, 1'b1, 0};
    vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A, 1'b1, STRETCH};

    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h00;

    // Reset values while rst_n is held low
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_rx_en", bus.rx_en, 0);
    chk("rst_ferr", bus.rx_frame_err, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_led", led, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_ready", bus.tx_ready, 1);
    repeat (5) @(negedge clk);

    // RX vector table
    for (int i = 0; i < 6; i++) begin
      r0 = rx_cnt; f0 = fe_cnt; l0 = led0_cyc;
      rx_frame(vecs[i].din, vecs[i].stop);
      repeat (40) @(negedge clk);
      chk($sformatf("rx%0d_en_count", i), rx_cnt - r0, vecs[i].exp_en);
      chk($sformatf("rx%0d_ferr_count", i), fe_cnt - f0, vecs[i].exp_fe);
      chk($sformatf("rx%0d_data", i), bus.rx_data, vecs[i].exp_dat);
      chk($sformatf("rx%0d_led2", i), led[2], vecs[i].exp_led2);
      chk($sformatf("rx%0d_led0_cycles", i), led0_cyc - l0, vecs[i].exp_led0);
    end
    led_clr = 1'b1;
    @(negedge clk);
    led_clr = 1'b0;
    chk("led2_cleared", led[2], 0);

    // 3-cycle glitch must be rejected; a following frame still decodes
    r0 = rx_cnt; f0 = fe_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_rx_en", rx_cnt - r0, 0);
    chk("glitch_no_ferr", fe_cnt - f0, 0);
    rx_frame(8'h96, 1'b1);
    repeat (40) @(negedge clk);
    chk("post_glitch_rx_en", rx_cnt - r0, 1);
    chk("post_glitch_data", bus.rx_data, 8'h96);

    // Two back-to-back pushes: start 2 clocks after first push, contiguous frames
    n0 = tx_starts.size();
    pc = cyc;
    bus.tx_en = 1'b1; bus.tx_data = 8'h55;
    @(negedge clk);
    bus.tx_data = 8'h01;
    @(negedge clk);
    bus.tx_en = 1'b0;
    chk("tx_start_latency", uart_txd, 0);
    chk("tx_led1_on", led[1], 1);
    repeat (STRETCH) @(negedge clk);
    chk("tx_led1_off", led[1], 0);
    k = 0;
    while (bus.tx_busy === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tx_busy_fall_cycle", cyc - pc, 2 + 20 * CLK_DIV);
    repeat (5) @(negedge clk);
    chk("tx_b2b_frames", tx_starts.size() - n0, 2);
    chk("tx_first_start", (tx_starts.size() > n0) ? tx_starts[n0] - pc : -1, 2);
    chk("tx_gap", (tx_starts.size() > n0 + 1) ? tx_starts[n0+1] - tx_starts[n0] : -1, 10 * CLK_DIV);
    chk("tx_word0", (tx_words.size() > n0) ? tx_words[n0] : 9'h0, {1'b1, 8'h55});
    chk("tx_word1", (tx_words.size() > n0 + 1) ? tx_words[n0+1] : 9'h0, {1'b1, 8'h01});

    // Overflow: one frame in flight, then 5 pushes; 4 stored, 5th dropped
    n0 = tx_starts.size();
    bus.tx_en = 1'b1; bus.tx_data = 8'h11;
    @(negedge clk);
    bus.tx_en = 1'b0;
    repeat (10) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      bus.tx_en = 1'b1;
      bus.tx_data = 8'h20 + 8'(j);
      if (j == 3) chk("ovf_ready_before_4th", bus.tx_ready, 1);
      if (j == 4) chk("ovf_ready_low_when_full", bus.tx_ready, 0);
      @(negedge clk);
    end
    bus.tx_en = 1'b0;
    chk("ovf_led3_set", led[3], 1);
    repeat (5 * 10 * CLK_DIV + 20) @(negedge clk);
    chk("ovf_frame_count", tx_starts.size() - n0, 5);
    exp_w[0] = 8'h11; exp_w[1] = 8'h20; exp_w[2] = 8'h21; exp_w[3] = 8'h22; exp_w[4] = 8'h23;
    for (int j = 0; j < 5; j++)
      chk($sformatf("ovf_word%0d", j), (tx_words.size() > n0 + j) ? tx_words[n0+j] : 9'h0, {1'b1, exp_w[j]});
    chk("ovf_busy_done", bus.tx_busy, 0);
    chk("ovf_led3_sticky", led[3], 1);
    led_clr = 1'b1;
    @(negedge clk);
    led_clr = 1'b0;
    chk("led3_cleared", led[3], 0);

    // Reset in the middle of a zero data bit with words still queued
    pc = cyc;
    bus.tx_en = 1'b1; bus.tx_data = 8'h00;
    @(negedge clk);
    bus.tx_data = 8'h7E;
    @(negedge clk);
    @(negedge clk);
    bus.tx_en = 1'b0;
    repeat (25) @(negedge clk);
    chk("rst_mid_pre_low", uart_txd, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_txd", uart_txd, 1);
    chk("rst_mid_busy", bus.tx_busy, 0);
    chk("rst_mid_ready", bus.tx_ready, 1);
    chk("rst_mid_led", led, 0);
    rst_n = 1'b1;
    n0 = tx_starts.size();
    repeat (300) @(negedge clk);
    chk("rst_mid_no_frames", tx_starts.size() - n0, 0);
    chk("rst_mid_txd_idle", uart_txd, 1);
    chk("rst_mid_busy_idle", bus.tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
